// File: rtl/p405s_icu_dp_fetchq.sv
// rtl/p405s_icu_dp_fetchq.sv - DEPTH x WIDTH fetch-word queue between ICU fill and decode (optional parity: P405S_ICU_FETCHQ_PARITY_EN)
module p405s_icu_dp_fetchq #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             CB,
    input  logic             RstL,
    input  logic [0:WIDTH-1] D,
    input  logic             E1,
    input  logic             Rd,
    input  logic             Flush,
    input  logic             ParInj,
    output logic [0:WIDTH-1] L2,
    output logic             Valid,
    output logic             Full,
    output logic [CW-1:0]    Count,
    output logic             WrDrop,
    output logic             ParErr
);

    logic [0:WIDTH-1] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Flush wins over everything; a full queue still accepts a push when the head is popped in the same cycle
    assign Valid = (Count != '0);
    assign Full  = (Count == CW'(DEPTH));
    assign pop   = Rd & Valid & ~Flush;
    assign push  = E1 & ~Flush & (~Full | Rd);
    assign L2    = Valid ? mem[rd_ptr] : '0;

    // Pointer, occupancy and drop-pulse bookkeeping
    always_ff @(posedge CB or negedge RstL) begin
        if (!RstL) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count  <= '0;
            WrDrop <= 1'b0;
        end else begin
            if (Flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                Count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                Count <= Count + CW'(push) - CW'(pop);
            end
            WrDrop <= E1 & Full & ~Rd & ~Flush;
        end
    end

    // Word storage; flush leaves contents in place, only the pointers move
    always_ff @(posedge CB or negedge RstL) begin
        if (!RstL) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= D;
        end
    end

`ifdef P405S_ICU_FETCHQ_PARITY_EN
    logic [DEPTH-1:0] par;

    // One parity bit per entry, optionally inverted to inject an error
    always_ff @(posedge CB or negedge RstL) begin
        if (!RstL) begin
            par <= '0;
        end else if (push) begin
            par[wr_ptr] <= (^D) ^ ParInj;
        end
    end

    assign ParErr = Valid & ((^L2) != par[rd_ptr]);
`else
    logic unused_par_inj;
    assign unused_par_inj = ParInj;
    assign ParErr         = 1'b0;
`endif

endmodule

// File: tb/tb_p405s_icu_dp_fetchq.sv
// tb/tb_p405s_icu_dp_fetchq.sv - self-checking bench for p405s_icu_dp_fetchq
module tb_p405s_icu_dp_fetchq;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             CB;
    logic             RstL;
    logic [0:WIDTH-1] D;
    logic             E1;
    logic             Rd;
    logic             Flush;
    logic             ParInj;
    logic [0:WIDTH-1] L2;
    logic             Valid;
    logic             Full;
    logic [CW-1:0]    Count;
    logic             WrDrop;
    logic             ParErr;

    p405s_icu_dp_fetchq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CB(CB), .RstL(RstL), .D(D), .E1(E1), .Rd(Rd), .Flush(Flush), .ParInj(ParInj),
        .L2(L2), .Valid(Valid), .Full(Full), .Count(Count), .WrDrop(WrDrop), .ParErr(ParErr)
    );

    initial CB = 1'b0;
    always #5 CB = ~CB;

    int errors = 0;
    int checks = 0;

`ifdef P405S_ICU_FETCHQ_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    // Reference model: an ordered list of words plus the injection flag of each
    logic [31:0] mq_data [$];
    bit          mq_inj  [$];
    bit          m_wrdrop;

    typedef struct {
        logic        e1;
        logic        rd;
        logic        fl;
        logic [31:0] d;
        logic [2:0]  cnt;
        logic [31:0] l2;
        logic        vld;
        logic        full;
        logic        wd;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(logic e1, logic rd, logic fl, logic [31:0] d,
                                logic [2:0] cnt, logic [31:0] l2, logic wd);
        vec_t v;
        v.e1 = e1; v.rd = rd; v.fl = fl; v.d = d;
        v.cnt = cnt; v.l2 = l2; v.vld = (cnt != 0); v.full = (cnt == 3'd4); v.wd = wd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq_data.delete();
        mq_inj.delete();
        m_wrdrop = 1'b0;
    endtask

    // Apply one cycle of inputs, clock it, and advance the model by the queue rules
    task automatic step(input logic e1, input logic rd, input logic fl,
                        input logic [31:0] d, input logic pi);
        bit full_b;
        bit pop_ok;
        bit push_ok;
        E1 = e1; Rd = rd; Flush = fl; D = d; ParInj = pi;
        @(posedge CB);
        #1;
        full_b = (mq_data.size() == DEPTH);
        if (fl) begin
            model_clear();
        end else begin
            pop_ok   = rd && (mq_data.size() > 0);
            push_ok  = e1 && (!full_b || rd);
            m_wrdrop = e1 && full_b && !rd;
            if (pop_ok) begin
                void'(mq_data.pop_front());
                void'(mq_inj.pop_front());
            end
            if (push_ok) begin
                mq_data.push_back(d);
                mq_inj.push_back(pi);
            end
        end
        E1 = 0; Rd = 0; Flush = 0; ParInj = 0;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] el2;
        logic        eperr;
        el2   = (mq_data.size() > 0) ? mq_data[0] : 32'h0;
        eperr = PAR_EN && (mq_data.size() > 0) && mq_inj[0];
        chk({tag, ".count"},  32'(Count),  32'(mq_data.size()));
        chk({tag, ".l2"},     L2,          el2);
        chk({tag, ".valid"},  32'(Valid),  32'(mq_data.size() > 0));
        chk({tag, ".full"},   32'(Full),   32'(mq_data.size() == DEPTH));
        chk({tag, ".wrdrop"}, 32'(WrDrop), 32'(m_wrdrop));
        chk({tag, ".parerr"}, 32'(ParErr), 32'(eperr));
    endtask

    initial begin
        RstL = 1'b0; E1 = 0; Rd = 0; Flush = 0; D = '0; ParInj = 0;
        model_clear();

        // Plan 1..4 plus empty-queue corners
        vecs.push_back(mk(1,0,0,32'h11111111, 1, 32'h11111111, 0));
        vecs.push_back(mk(1,0,0,32'h22222222, 2, 32'h11111111, 0));
        vecs.push_back(mk(1,0,0,32'h33333333, 3, 32'h11111111, 0));
        vecs.push_back(mk(1,0,0,32'h44444444, 4, 32'h11111111, 0));
        vecs.push_back(mk(1,0,0,32'h55555555, 4, 32'h11111111, 1));
        vecs.push_back(mk(0,1,0,32'h0,        3, 32'h22222222, 0));
        vecs.push_back(mk(0,1,0,32'h0,        2, 32'h33333333, 0));
        vecs.push_back(mk(0,1,0,32'h0,        1, 32'h44444444, 0));
        vecs.push_back(mk(0,1,0,32'h0,        0, 32'h0,        0));
        vecs.push_back(mk(1,0,0,32'h11111111, 1, 32'h11111111, 0));
        vecs.push_back(mk(1,0,0,32'h22222222, 2, 32'h11111111, 0));
        vecs.push_back(mk(1,0,0,32'h33333333, 3, 32'h11111111, 0));
        vecs.push_back(mk(1,0,0,32'h44444444, 4, 32'h11111111, 0));
        vecs.push_back(mk(1,1,0,32'hAAAAAAAA, 4, 32'h22222222, 0));
        vecs.push_back(mk(0,1,0,32'h0,        3, 32'h33333333, 0));
        vecs.push_back(mk(0,1,0,32'h0,        2, 32'h44444444, 0));
        vecs.push_back(mk(0,1,0,32'h0,        1, 32'hAAAAAAAA, 0));
        vecs.push_back(mk(1,0,0,32'hBBBBBBBB, 2, 32'hAAAAAAAA, 0));
        vecs.push_back(mk(1,0,0,32'hCCCCCCCC, 3, 32'hAAAAAAAA, 0));
        vecs.push_back(mk(1,1,1,32'hEEEEEEEE, 0, 32'h0,        0));
        vecs.push_back(mk(1,0,0,32'hDEADBEEF, 1, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0,1,0,32'h0,        0, 32'h0,        0));
        vecs.push_back(mk(0,1,0,32'h0,        0, 32'h0,        0));
        vecs.push_back(mk(1,1,0,32'h12345678, 1, 32'h12345678, 0));
        vecs.push_back(mk(1,0,0,32'h0,        2, 32'h12345678, 0));
        vecs.push_back(mk(1,0,0,32'h0,        3, 32'h12345678, 0));
        vecs.push_back(mk(1,0,0,32'h0,        4, 32'h12345678, 0));
        vecs.push_back(mk(1,0,1,32'h0,        0, 32'h0,        0));

        repeat (2) @(posedge CB);
        #1;
        chk("reset.count", 32'(Count), 32'h0);
        chk("reset.valid", 32'(Valid), 32'h0);
        chk("reset.full",  32'(Full),  32'h0);
        chk("reset.l2",    L2,         32'h0);
        chk("reset.wrdrop",32'(WrDrop),32'h0);
        chk("reset.parerr",32'(ParErr),32'h0);
        @(negedge CB);
        RstL = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].e1, vecs[i].rd, vecs[i].fl, vecs[i].d, 1'b0);
            chk($sformatf("vec%0d.count", i),  32'(Count),  32'(vecs[i].cnt));
            chk($sformatf("vec%0d.l2", i),     L2,          vecs[i].l2);
            chk($sformatf("vec%0d.valid", i),  32'(Valid),  32'(vecs[i].vld));
            chk($sformatf("vec%0d.full", i),   32'(Full),   32'(vecs[i].full));
            chk($sformatf("vec%0d.wrdrop", i), 32'(WrDrop), 32'(vecs[i].wd));
            chk($sformatf("vec%0d.parerr", i), 32'(ParErr), 32'h0);
        end

        // Asynchronous reset between edges with two words held
        step(1, 0, 0, 32'h01020304, 0);
        step(1, 0, 0, 32'h05060708, 0);
        chk("arst.pre_count", 32'(Count), 32'h2);
        #2 RstL = 1'b0;
        #1;
        chk("arst.count", 32'(Count), 32'h0);
        chk("arst.valid", 32'(Valid), 32'h0);
        chk("arst.l2",    L2,         32'h0);
        #1 RstL = 1'b1;
        model_clear();
        step(1, 0, 0, 32'hCAFEF00D, 0);
        check_model("arst.after");

        // Parity injection on the first word only
        step(0, 0, 1, 32'h0, 0);
        step(1, 0, 0, 32'h0000000F, 1);
        check_model("par.first");
        chk("par.first_abs", 32'(ParErr), 32'(PAR_EN));
        step(1, 0, 0, 32'h00000001, 0);
        check_model("par.second");
        step(0, 1, 0, 32'h0, 0);
        check_model("par.popped");
        chk("par.popped_abs", 32'(ParErr), 32'h0);
        step(0, 1, 0, 32'h0, 0);
        check_model("par.empty");

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic e1_r, rd_r, fl_r, pi_r;
            e1_r = ($urandom_range(0, 99) < 60);
            rd_r = ($urandom_range(0, 99) < 45);
            fl_r = ($urandom_range(0, 99) < 3);
            pi_r = ($urandom_range(0, 99) < 20);
            step(e1_r, rd_r, fl_r, $urandom, pi_r);
            check_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/p405s_icu_dp_fetchq.md
Name: p405s_icu_dp_fetchq

Overview:
- Parametrised successor to the single ICU datapath enable register: a DEPTH-entry by WIDTH-bit queue of fetch words sitting between the ICU fill datapath and the instruction decode hand-off.
- Words are captured on E1 as before, but they are buffered, popped in order, flushable and occupancy-tracked instead of being overwritten.
- Head entry is presented on L2 so downstream logic sees a register-like output.

Parameters:
WIDTH, 32, data word width; bit order [0:WIDTH-1], bit 0 is MSB.
DEPTH, 4, number of entries; power of two, ≥2.
CW, clog2(DEPTH+1), width of Count; derived, not overridden.

Ports:
CB  input  1  clock, rising-edge.
RstL  input  1  asynchronous active-low reset.
D  input  WIDTH  write data.
E1  input  1  write enable (push request).
Rd  input  1  pop request for head entry.
Flush  input  1  discard all entries.
ParInj  input  1  corrupt stored parity of the word written this cycle (feature only).
L2  output  WIDTH  head entry data; all zeros when empty.
Valid  output  1  queue non-empty (L2 meaningful).
Full  output  1  Count == DEPTH.
Count  output  CW  current occupancy, 0..DEPTH.
WrDrop  output  1  one-cycle pulse: push refused.
ParErr  output  1  head parity mismatch (feature only).

Behaviour:
- Reset (RstL low, asynchronous): write pointer and read pointer = 0; Count = 0; all storage = 0; WrDrop = 0. Consequently L2 = 0, Valid = 0, Full = 0, ParErr = 0.
- Reset asserted mid-operation discards all contents immediately, with no clock needed. First push after deassertion lands in entry 0.
- Storage: DEPTH registers, written only on an accepted push.
- Pointers: log2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
- Flush (highest priority):
  - Next edge sets pointers and Count to 0; storage is untouched.
  - Same-cycle E1 and Rd are ignored.
  - WrDrop stays 0 during Flush.
- Pop accepted = Rd & Valid & !Flush. Rd when empty is a no-op with no error.
- Push accepted = E1 & !Flush & (!Full | Rd).
  - Simultaneous push and pop when full is allowed; Count is unchanged.
- WrDrop is registered, asserted the edge after E1 & Full & !Rd & !Flush, and low otherwise.
- Count next value = Count + push − pop.
- Simultaneous push and pop when empty: pop is not accepted (Valid = 0), so the push lands and Count becomes 1.
- Latency: word pushed at edge N appears on L2 with Valid = 1 after edge N (zero bypass; D is never passed combinationally to L2).
- L2 = storage[rd_ptr] when Valid, else all zeros. It is combinational from registers only.
- Valid, Full and ParErr are decoded from registered state only; there are no paths from inputs to outputs.

Optional Feature:
- Macro: P405S_ICU_FETCHQ_PARITY_EN.
- Defined:
  - Each entry gains one parity bit written as the XOR-reduction of D, inverted when ParInj = 1. Reset value is 0.
  - ParErr = Valid & (XOR(L2) != stored parity of head).
  - Flush and pop behave as normal; no sticky error state.
- Undefined:
  - No parity storage.
  - ParErr is tied 0 and ParInj is ignored.
  - Port list is identical in both builds.

Test Plan:
1. Reset then push 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles -> Count 1,2,3,4; Full = 1 after 4th edge; L2 = 0x11111111 throughout.
2. Full, E1 with D = 0x55555555 and Rd = 0 -> WrDrop pulses one cycle, Count stays 4; then four pops -> L2 sequence 0x11111111..0x44444444, then Valid = 0 and L2 = 0.
3. Full, E1 and Rd together with D = 0xAAAAAAAA -> Count stays 4; L2 advances to 0x22222222; after 3 more pops L2 = 0xAAAAAAAA (pointer wrap checked).
4. Count = 3, Flush with E1 and Rd high -> next cycle Count = 0, Valid = 0, WrDrop = 0; a subsequent push of 0xDEADBEEF appears on L2.
5. RstL pulsed low between clock edges with Count = 2 -> Count, Valid and L2 go to 0 immediately, before the next edge.
6. (P405S_ICU_FETCHQ_PARITY_EN) push 0x0000000F with ParInj = 1, then 0x00000001 with ParInj = 0 -> ParErr = 1 while the first word is head; after pop ParErr = 0. Non-feature build: ParErr = 0 throughout.
